// File: rtl/pipelined_mdu_alu.sv
// EX-stage ALU with registered single-cycle ops and iterative unsigned MULTU/DIVU into HI/LO.
// Multi-cycle ops run IDLE -> RUN (WIDTH steps) -> FINISH; busy stalls the pipeline meanwhile.
module pipelined_mdu_alu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOR   = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_MULTU = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
    localparam logic [3:0] OP_MFHI  = 4'd10;
    localparam logic [3:0] OP_MFLO  = 4'd11;

    function automatic logic [WIDTH-1:0] alu_result(
        input logic [3:0]       f,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] h,
        input logic [WIDTH-1:0] l
    );
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (f)
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLT:  return {{(WIDTH-1){1'b0}}, (sa < sb)};
            OP_SLTU: return {{(WIDTH-1){1'b0}}, (a < b)};
            OP_MFHI: return h;
            OP_MFLO: return l;
            default: return '0;
        endcase
    endfunction

    // One shift-add step: conditionally add the multiplicand to the upper half, then shift right.
    function automatic logic [2*WIDTH-1:0] mul_step(
        input logic [WIDTH-1:0] ah,
        input logic [WIDTH-1:0] al,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH:0] sum;
        sum = {1'b0, ah} + (al[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
        return {sum, al[WIDTH-1:1]};
    endfunction

    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    function automatic logic [2*WIDTH-1:0] div_step(
        input logic [WIDTH-1:0] ah,
        input logic [WIDTH-1:0] al,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH:0]   sh;
        logic [WIDTH-1:0] diff;
        logic             ge;
        sh   = {ah, al[WIDTH-1]};
        ge   = (sh >= {1'b0, d});
        diff = sh[WIDTH-1:0] - d;
        return {(ge ? diff : sh[WIDTH-1:0]), al[WIDTH-2:0], ge};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               zero_q, zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic [2*WIDTH-1:0] step_w;

    assign step_w = is_div_q ? div_step(acc_hi_q, acc_lo_q, opnd_q)
                             : mul_step(acc_hi_q, acc_lo_q, opnd_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    zero_d = (in1 == in2);
                    if (op == OP_MULTU || op == OP_DIVU) begin
                        state_d  = RUN;
                        cnt_d    = '0;
                        acc_hi_d = '0;
                        is_div_d = (op == OP_DIVU);
                        acc_lo_d = (op == OP_DIVU) ? in1 : in2;
                        opnd_d   = (op == OP_DIVU) ? in2 : in1;
                    end else begin
                        out_d  = alu_result(op, in1, in2, hi_q, lo_q);
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                {acc_hi_d, acc_lo_d} = step_w;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                hi_d    = acc_hi_q;
                lo_d    = acc_lo_q;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Working registers are only read in RUN/FINISH after being loaded, so they need no reset.
    always_ff @(posedge clk) begin
        acc_hi_q <= acc_hi_d;
        acc_lo_q <= acc_lo_d;
        opnd_q   <= opnd_d;
        is_div_q <= is_div_d;
    end

    assign out  = out_q;
    assign zero = zero_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_pipelined_mdu_alu.sv
// Directed scoreboard bench for pipelined_mdu_alu: driver queues expected results, monitor checks on done.
module tb_pipelined_mdu_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic [W-1:0] out;
    logic         zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;

    pipelined_mdu_alu #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .in1   (in1),
        .in2   (in2),
        .out   (out),
        .zero  (zero),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic         zero;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1 (out=0x%h hi=0x%h lo=0x%h) expected no pending result",
                         out, hi, lo);
            end else begin
                mon_e = sb_q.pop_front();
                if (out !== mon_e.out || zero !== mon_e.zero || hi !== mon_e.hi || lo !== mon_e.lo) begin
                    n_fail++;
                    $display("FAIL %s: got out=0x%h zero=%b hi=0x%h lo=0x%h expected out=0x%h zero=%b hi=0x%h lo=0x%h",
                             mon_e.name, out, zero, hi, lo, mon_e.out, mon_e.zero, mon_e.hi, mon_e.lo);
                end
            end
        end
    end

    task automatic issue_raw(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eo, input logic ez, input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_t e;
        e.name = name;
        e.out  = eo;
        e.zero = ez;
        e.hi   = eh;
        e.lo   = el;
        sb_q.push_back(e);
        issue_raw(o, a, b);
    endtask

    // Called just after the accepting edge; counts edges until done and cycles with busy high.
    task automatic wait_mc(input string name);
        int k;
        int nb;
        k  = 0;
        nb = busy ? 1 : 0;
        while (!done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (busy) nb++;
        end
        check({name, "_latency"}, k, 33);
        check({name, "_busy_cycles"}, nb, 33);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        #2 rst = 1'b1;
        @(negedge clk);
        check("reset_out",  out,  0);
        check("reset_zero", zero, 0);
        check("reset_hi",   hi,   0);
        check("reset_lo",   lo,   0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        issue("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h0, 32'h0);
        check("add_done_latency", done, 1);
        @(posedge clk);
        #1 check("add_done_single_pulse", done, 0);
        issue("sub_equal", 4'd1, 32'd5, 32'd5, 32'h0, 1'b1, 32'h0, 32'h0);

        issue("slt_neg", 4'd6, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 32'h0, 32'h0);
        issue("sltu_big", 4'd7, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 32'h0, 32'h0);
        issue("nor_zero", 4'd5, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h0);

        issue("multu_max", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h1);
        wait_mc("multu_max");
        issue("mfhi", 4'd10, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFE, 32'h1);
        issue("mflo", 4'd11, 32'h0, 32'h1, 32'h1, 1'b0, 32'hFFFF_FFFE, 32'h1);

        issue("divu_100_7", 4'd9, 32'd100, 32'd7, 32'h1, 1'b0, 32'd2, 32'd14);
        wait_mc("divu_100_7");
        issue("divu_by_zero", 4'd9, 32'h1234, 32'h0, 32'h1, 1'b0, 32'h1234, 32'hFFFF_FFFF);
        wait_mc("divu_by_zero");

        issue("multu_3_4", 4'd8, 32'd3, 32'd4, 32'h1, 1'b0, 32'h0, 32'd12);
        repeat (3) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        op    = 4'd9;
        in1   = 32'd100;
        in2   = 32'd7;
        @(negedge clk);
        in1   = 32'd5;
        in2   = 32'd9;
        @(negedge clk);
        start = 1'b0;
        in1   = 32'hDEAD_BEEF;
        in2   = 32'h0;
        k = 0;
        while (!done && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("multu_3_4_done_seen", done, 1);
        repeat (40) @(posedge clk);
        #1;
        check("ignored_divu_hi",   hi,   0);
        check("ignored_divu_lo",   lo,   12);
        check("ignored_divu_busy", busy, 0);

        issue_raw(4'd8, 32'd7, 32'd9);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_hi",   hi,   0);
        check("async_rst_lo",   lo,   0);
        check("async_rst_out",  out,  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue("add_after_rst", 4'd0, 32'd2, 32'd3, 32'd5, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
